// File: rtl/mem_stage.sv
// Memory stage: single-port word memory with configurable read latency,
// out-of-range detection, and branch/jump resolution (PCSrc).
module mem_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] memAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic              memWr,
   input  logic              memRd,
   input  logic [2:0]        flags,
   input  logic [2:0]        branchOp,
   input  logic              sawBr,
   input  logic              sawJ,
   output logic [DATA_W-1:0] rdData,
   output logic              rdValid,
   output logic              stall,
   output logic              addrErr,
   output logic              PCSrc
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam bit LAT1 = (RD_LAT == 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state, state_next;
   logic [2:0]        cnt, cnt_next;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_oor;
   logic              in_range;
   logic              acc_rd;
   logic              acc_wr;
   logic              load;
   logic              cond;

   assign idx      = memAddr[IDX_W-1:0];
   assign in_range = ({1'b0, memAddr} < DEPTH_EXT);
   // Requests are only sampled in IDLE and never while reset is held.
   assign acc_wr   = rst_n & (state == IDLE) & memWr;
   assign acc_rd   = rst_n & (state == IDLE) & memRd;
   assign stall    = (state == BUSY);

   always_ff @(posedge clk) begin
      if (acc_wr && in_range) begin
         mem[idx] <= wrData;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (acc_rd) begin
               if (LAT1) begin
                  load = 1'b1;
               end else begin
                  state_next = BUSY;
                  cnt_next   = 3'(RD_LAT - 1);
               end
            end
         end
         BUSY: begin
            cnt_next = cnt - 3'd1;
            if (cnt == 3'd1) begin
               load       = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         rd_idx  <= '0;
         rd_oor  <= 1'b0;
         addrErr <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         addrErr <= (acc_rd | acc_wr) & ~in_range;
         if (acc_rd) begin
            rd_idx <= idx;
            rd_oor <= ~in_range;
         end
      end
   end

   // With unit latency the load coincides with acceptance, so a same-cycle
   // write must be forwarded to give write-first behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdData  <= '0;
         rdValid <= 1'b0;
      end else begin
         rdValid <= load;
         if (load) begin
            if (LAT1 ? ~in_range : rd_oor) begin
               rdData <= '0;
            end else if (LAT1 && memWr) begin
               rdData <= wrData;
            end else begin
               rdData <= mem[LAT1 ? idx : rd_idx];
            end
         end
      end
   end

   always_comb begin
      cond = 1'b0;
      case (branchOp)
         3'b000:  cond = ~flags[1];
         3'b001:  cond = flags[1];
         3'b010:  cond = ~flags[1] & ~flags[2];
         3'b011:  cond = flags[2];
         3'b100:  cond = ~flags[2];
         3'b101:  cond = flags[2] | flags[1];
         3'b110:  cond = flags[0];
         default: cond = 1'b1;
      endcase
   end

   assign PCSrc = (sawBr & cond) | sawJ;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter DEPTH, default 1024, word count; power of two, at most 2^ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- memAddr  in  ADDR_W  word address.
- wrData  in  DATA_W  write data.
- memWr  in  1  write request.
- memRd  in  1  read request.
- flags  in  3  {N,Z,V}.
- branchOp  in  3  branch condition code.
- sawBr  in  1  branch instruction present.
- sawJ  in  1  jump instruction present.
- rdData  out  DATA_W  registered read data.
- rdValid  out  1  one-cycle pulse; rdData is new.
- stall  out  1  read in flight; upstream holds inputs.
- addrErr  out  1  one-cycle pulse; out-of-range access.
- PCSrc  out  1  take branch/jump.

Function
REQ-006 SHALL hold DEPTH x DATA_W words, indexed by memAddr[log2(DEPTH)-1:0]; access SHALL be in range only when memAddr < DEPTH.
REQ-007 SHALL implement FSM IDLE/BUSY; stall SHALL be 1 exactly when in BUSY.
REQ-008 SHALL sample requests only in IDLE: memWr/memRd asserted while BUSY are ignored, with no state change and no write.
REQ-009 SHALL, on an in-range write in IDLE (memWr=1 at edge E), update the word at edge E; writes never stall.
REQ-010 SHALL, on a read accepted at edge E, load rdData and pulse rdValid in the cycle after edge E+RD_LAT-1.
REQ-011 SHALL, for RD_LAT=1, stay in IDLE and never assert stall.
REQ-012 SHALL, for RD_LAT>1, enter BUSY at E with down-counter=RD_LAT-1, decrement each edge, and return to IDLE on the edge that loads rdData; stall is high for RD_LAT-1 cycles.
REQ-013 SHALL capture the read address at acceptance; memAddr changes while BUSY do not affect the result.
REQ-014 SHALL, with memRd and memWr both set in IDLE, perform the write and the read to the same address; the read returns the newly written data (write-first).
REQ-015 SHALL return new data for a read accepted the cycle after a write to the same address.
REQ-016 SHALL hold rdData between loads; rdValid is 0 except in the load cycle.
REQ-017 SHALL, for an out-of-range accepted access, suppress the write, pulse addrErr in the cycle after the acceptance edge, and for a read deliver rdData=0 with normal rdValid timing.
REQ-018 SHALL decode branchOp: 000 BNEQ (Z=0), 001 BEQ (Z=1), 010 BGT (Z=0 & N=0), 011 BLT (N=1), 100 BGTE (N=0), 101 BLTE (N=1 | Z=1), 110 BOVFL (V=1), 111 BUNCOND (always).
REQ-019 SHALL drive PCSrc combinationally = (sawBr & cond) | sawJ, independent of FSM state.

Reset
REQ-020 SHALL, while rst_n=0, force asynchronously: state IDLE, counter 0, rdData 0, rdValid 0, stall 0, addrErr 0.
REQ-021 SHALL abort an in-flight read on reset, with no rdValid afterwards; memory contents are not reset.
REQ-022 SHALL keep PCSrc combinational during reset.
REQ-023 SHALL accept requests from the first rising edge after rst_n deasserts.

Verification
REQ-024 SHALL cover: RD_LAT=1; write 0xBEEF to address 5, then read 5 -> rdData=0xBEEF, rdValid for 1 cycle one cycle after acceptance, stall never high.
REQ-025 SHALL cover: RD_LAT=3; read address 5 -> stall high 2 cycles, rdValid 3rd cycle; memAddr changed to 6 mid-read -> still address-5 data; memWr pulse during stall -> no write.
REQ-026 SHALL cover: memRd=memWr=1, address 9, wrData 0x1234 -> rdData=0x1234; later read of 9 -> 0x1234.
REQ-027 SHALL cover: DEPTH=1024; write to address 1024 -> addrErr pulse, address 0 unchanged; read 2000 -> rdData=0, addrErr pulse.
REQ-028 SHALL cover: rst_n low during BUSY with RD_LAT=4 -> stall, rdValid and rdData immediately 0, no later rdValid.
REQ-029 SHALL cover: all 8 branchOp codes x flag patterns; sawBr=1, BLTE, flags=100 -> PCSrc=1; sawBr=0, sawJ=1 -> PCSrc=1; sawBr=sawJ=0 -> PCSrc=0.
